// File: rtl/mod_addsub_pipe_if.sv
// Operand/result handshake bundle for the modular add/sub pipeline.
// master = producer/consumer around the block, slave = the pipeline itself.
interface mod_addsub_pipe_if #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned COUNT_W = 16
);
   // input side
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_op;
   logic [TAG_W-1:0]   in_tag;
   // output side
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [TAG_W-1:0]   out_tag;
   logic               out_err;
   logic [COUNT_W-1:0] done_count;

   modport master (
      output in_valid, in_a, in_b, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_err, done_count
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_err, done_count
   );
endinterface

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor: (a +/- b) mod MODULUS.
// Stage 1 forms the uncorrected WIDTH+1 bit sum, stage 2 applies a single
// conditional subtraction of the modulus. Valid/ready flow control with
// bubble collapsing; tags ride alongside; consumed results are counted.
module mod_addsub_pipe #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned MODULUS = 12289,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   mod_addsub_pipe_if.slave   bus
);

   localparam int unsigned RAW_W = WIDTH + 1;
   localparam logic [WIDTH-1:0] Q_W   = WIDTH'(MODULUS);
   localparam logic [RAW_W-1:0] Q_RAW = RAW_W'(MODULUS);

   // stage 1 state
   logic               r_s1_v;
   logic [RAW_W-1:0]   r_s1_raw;
   logic [TAG_W-1:0]   r_s1_tag;
   logic               r_s1_err;

   // stage 2 (output) state
   logic               r_s2_v;
   logic [WIDTH-1:0]   r_s2_data;
   logic [TAG_W-1:0]   r_s2_tag;
   logic               r_s2_err;

   logic [COUNT_W-1:0] r_done_count;

   // combinational datapath and handshake terms
   logic               w_en1;
   logic               w_en2;
   logic               w_accept;
   logic               w_consume;
   logic [RAW_W-1:0]   w_a_ext;
   logic [RAW_W-1:0]   w_b_ext;
   logic [RAW_W-1:0]   w_b_term;
   logic [RAW_W-1:0]   w_raw;
   logic               w_err;
   logic [WIDTH-1:0]   w_s2_data;

   // Flow control: a stage may load when it is empty or its successor moves.
   always_comb begin
      w_en2     = !r_s2_v || bus.out_ready;
      w_en1     = !r_s1_v || w_en2;
      w_accept  = bus.in_valid && w_en1;
      w_consume = r_s2_v && bus.out_ready;
   end

   // Stage 1 arithmetic: subtraction is done as a + (q - b) so the sum
   // stays non-negative for in-range operands and fits in WIDTH+1 bits.
   always_comb begin
      w_a_ext  = {1'b0, bus.in_a};
      w_b_ext  = {1'b0, bus.in_b};
      w_b_term = bus.in_op ? (Q_RAW - w_b_ext) : w_b_ext;
      w_raw    = w_a_ext + w_b_term;
      w_err    = (bus.in_a >= Q_W) || (bus.in_b >= Q_W);
   end

   // Stage 2 arithmetic: one conditional correction brings raw into [0, q).
   always_comb begin
      w_s2_data = (r_s1_raw >= Q_RAW) ? WIDTH'(r_s1_raw - Q_RAW)
                                      : WIDTH'(r_s1_raw);
   end

   // Stage 1 register: valid follows in_valid whenever the stage may load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v   <= 1'b0;
         r_s1_raw <= '0;
         r_s1_tag <= '0;
         r_s1_err <= 1'b0;
      end else begin
         if (w_en1) begin
            r_s1_v <= bus.in_valid;
         end
         if (w_accept) begin
            r_s1_raw <= w_raw;
            r_s1_tag <= bus.in_tag;
            r_s1_err <= w_err;
         end
      end
   end

   // Stage 2 register: payload only moves with a valid stage-1 entry so
   // held results stay stable under back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_v    <= 1'b0;
         r_s2_data <= '0;
         r_s2_tag  <= '0;
         r_s2_err  <= 1'b0;
      end else begin
         if (w_en2) begin
            r_s2_v <= r_s1_v;
         end
         if (w_en2 && r_s1_v) begin
            r_s2_data <= w_s2_data;
            r_s2_tag  <= r_s1_tag;
            r_s2_err  <= r_s1_err;
         end
      end
   end

   // Completed-transaction counter, wraps naturally at 2^COUNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done_count <= '0;
      end else if (w_consume) begin
         r_done_count <= r_done_count + COUNT_W'(1);
      end
   end

   // Output drive: in_ready is the only combinational output.
   always_comb begin
      bus.in_ready   = w_en1;
      bus.out_valid  = r_s2_v;
      bus.out_data   = r_s2_data;
      bus.out_tag    = r_s2_tag;
      bus.out_err    = r_s2_err;
      bus.done_count = r_done_count;
   end

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
- Parametrised, pipelined modular adder/subtractor for the NTT butterfly datapath.
- Computes (a + b) mod q or (a − b) mod q per transaction.
- Generalises the single-bit full-adder to WIDTH-bit operands with modular correction, a per-transaction mode bit, valid/ready flow control, tag passthrough and a completion counter.
- Sits between coefficient memory reads and the butterfly output register.

Parameters:
WIDTH, 16, operand/result width in bits
MODULUS, 12289, modulus q; must satisfy 2 <= MODULUS < 2^WIDTH
TAG_W, 4, width of the opaque tag carried alongside each operand pair
COUNT_W, 16, width of the completed-transaction counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
in_a  in  WIDTH  operand a, expected < MODULUS
in_b  in  WIDTH  operand b, expected < MODULUS
in_op  in  1  0 = add, 1 = subtract (a − b)
in_tag  in  TAG_W  tag, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  WIDTH  result, in [0, MODULUS)
out_tag  out  TAG_W  tag of this result
out_err  out  1  this result came from an out-of-range operand (a >= q or b >= q)
done_count  out  COUNT_W  number of results consumed (out_valid & out_ready)

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: all stage valids, out_valid, out_data, out_tag, out_err and done_count are 0.
- Reset mid-operation discards all in-flight transactions.
- Stage 1 register (on input accept):
  - raw = a + (op ? (q − b) : b), computed WIDTH+1 bits wide with no truncation.
  - Also registers tag, plus err = (a >= q) | (b >= q).
- Stage 2 register (output):
  - data = (raw >= q) ? raw − q : raw, truncated to WIDTH bits.
  - tag and err are forwarded unchanged.
- For in-range operands the result is always exact.
  - Example: b = 0 with op = 1 gives raw = a + q, so the output is a.
- Out-of-range operands are still processed with the same formula. The result is deterministic but not meaningful, and out_err = 1.
- Flow control, with s1v/s2v the stage valids:
  - en2 = !s2v | out_ready
  - en1 = !s1v | en2
  - in_ready = en1, purely combinational from state and out_ready
  - Input accepted when in_valid & in_ready; s1v loads in_valid when en1.
  - s2v loads s1v when en2; stage-2 data loads only when en2 & s1v.
- Latency: 2 cycles from accept to out_valid when not stalled. Throughput: 1 result per cycle.
- Back-pressure:
  - While out_ready = 0 and both stages are full, in_ready = 0 and out_data/out_tag/out_err hold stable.
  - Holding out_valid with stable outputs is mandatory; no result is dropped or duplicated.
- Simultaneous accept and consume with both stages full: both happen in the same cycle and the pipeline shifts.
- Bubbles: an empty stage 1 advances into stage 2 as invalid; bubbles are collapsed by the en1 term.
- done_count increments by 1 on each out_valid & out_ready cycle and wraps modulo 2^COUNT_W.
- in_* values are sampled only on accept; changes while in_ready = 0 have no effect.

Test Plan:
- Reset:
  - Assert rst asynchronously mid-cycle with 2 transactions in flight -> out_valid = 0 and done_count = 0 immediately.
  - After release -> in_ready = 1 and no stale result appears.
- Add wrap (q = 12289, out_ready = 1):
  - a = 12000, b = 500, op = 0, tag = 3 -> out_data = 211, out_tag = 3, out_err = 0, exactly 2 cycles after accept.
  - a = 5, b = 7, op = 0 -> 12.
- Subtract:
  - a = 5, b = 7, op = 1 -> 12287.
  - a = 7, b = 7, op = 1 -> 0.
  - a = 100, b = 0, op = 1 -> 100.
  - a = 12288, b = 12288, op = 0 -> 12287.
- Back-pressure:
  - Stream tags 0..5 back-to-back, with out_ready low for 4 cycles after the first result.
  - Required: in_ready drops once both stages are full; held output stays stable.
  - Results emerge in order 0..5 with correct values; done_count = 6.
- Out-of-range:
  - a = 12289, b = 1, op = 0 -> out_err = 1 on that result only.
  - The following in-range transaction -> out_err = 0.
- Random soak:
  - 10,000 random in-range transactions with random in_valid/out_ready and mixed op.
  - Scoreboard matches (a ± b) mod q and tag order; done_count = 10000 mod 2^16.
